// File: rtl/nn_layer_sequencer.sv
// Sequencer for one fully connected layer: clears the layer, requests MAC steps,
// serves the input vector from a local buffer and captures the activated outputs.
module nn_layer_sequencer #(
    parameter int N_IN    = 2,
    parameter int N_OUT   = 2,
    parameter int DW      = 8,
    parameter int AW      = 1,
    parameter int CLR_CYC = 2,
    parameter int WDOG    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_we,
    input  logic [AW-1:0]        in_addr,
    input  logic signed [DW-1:0] in_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 layer_rst,
    output logic                 layer_req,
    input  logic                 step_ack,
    input  logic                 layer_ack,
    input  logic                 x_trig,
    input  logic [AW-1:0]        x_addr,
    output logic signed [DW-1:0] x_data,
    output logic                 x_valid,
    input  logic [N_OUT*DW-1:0]  y_in,
    output logic [N_OUT*DW-1:0]  y_out
);
    localparam int SW = $clog2(N_IN + 1);
    localparam int WW = $clog2(WDOG + 1);
    localparam int CW = $clog2(CLR_CYC + 1);
    localparam int AL = AW + 1;

    localparam logic [SW-1:0] STEP_LAST = SW'(N_IN);
    localparam logic [WW-1:0] WDOG_INIT = WW'(WDOG);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC);
    localparam logic [AL-1:0] ADDR_LIM  = AL'(N_IN);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT_OUT, DONE} state_t;

    state_t               state;
    logic [SW-1:0]        step_cnt;
    logic [WW-1:0]        wdog_cnt;
    logic [CW-1:0]        clr_cnt;
    logic                 abort;
    logic                 wdog_expire;
    logic signed [DW-1:0] buf_mem [N_IN];

    assign wdog_expire = (wdog_cnt == WW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) buf_mem[i] <= '0;
        end else if (in_we && state == IDLE && {1'b0, in_addr} < ADDR_LIM) begin
            buf_mem[in_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_valid <= 1'b0;
            x_data  <= '0;
        end else begin
            x_valid <= x_trig;
            if (x_trig) x_data <= ({1'b0, x_addr} < ADDR_LIM) ? buf_mem[x_addr] : '0;
        end
    end

    // abort remembers a watchdog expiry so CLEAR returns to IDLE instead of RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            layer_rst <= 1'b1;
            layer_req <= 1'b0;
            y_out     <= '0;
            step_cnt  <= '0;
            wdog_cnt  <= '0;
            clr_cnt   <= '0;
            abort     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    layer_rst <= 1'b0;
                    layer_req <= 1'b0;
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        abort    <= 1'b0;
                        step_cnt <= '0;
                        wdog_cnt <= WDOG_INIT;
                        clr_cnt  <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        layer_rst <= 1'b0;
                        if (abort) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= RUN;
                            layer_req <= 1'b1;
                        end
                    end else begin
                        layer_rst <= 1'b1;
                        clr_cnt   <= clr_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (wdog_expire) begin
                        err       <= 1'b1;
                        abort     <= 1'b1;
                        layer_req <= 1'b0;
                        clr_cnt   <= '0;
                        wdog_cnt  <= '0;
                        state     <= CLEAR;
                    end else begin
                        wdog_cnt <= wdog_cnt - WW'(1);
                        if (step_ack) begin
                            step_cnt <= step_cnt + SW'(1);
                            if (step_cnt + SW'(1) == STEP_LAST) begin
                                layer_req <= 1'b0;
                                state     <= WAIT_OUT;
                            end
                        end
                    end
                end
                WAIT_OUT: begin
                    if (layer_ack) begin
                        y_out <= y_in;
                        state <= DONE;
                    end else if (wdog_expire) begin
                        err      <= 1'b1;
                        abort    <= 1'b1;
                        clr_cnt  <= '0;
                        wdog_cnt <= '0;
                        state    <= CLEAR;
                    end else begin
                        wdog_cnt <= wdog_cnt - WW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Randomized self-checking bench for nn_layer_sequencer; a behavioural layer
// model drives the handshakes and a model buffer predicts every read.
`timescale 1ns/1ps
module tb_nn_layer_sequencer;
    localparam int N_IN    = 2;
    localparam int N_OUT   = 2;
    localparam int DW      = 8;
    localparam int AW      = 1;
    localparam int CLR_CYC = 2;
    localparam int WDOG_A  = 16;
    localparam int N_IN_B  = 3;
    localparam int AW_B    = 2;
    localparam int WDOG_B  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 start, in_we, step_ack, layer_ack, x_trig;
    logic [AW-1:0]        in_addr, x_addr;
    logic [DW-1:0]        in_data, x_data;
    logic                 busy, done, err, layer_rst, layer_req, x_valid;
    logic [N_OUT*DW-1:0]  y_in, y_out;

    logic                 start_b, in_we_b, step_ack_b, layer_ack_b, x_trig_b;
    logic [AW_B-1:0]      in_addr_b, x_addr_b;
    logic [DW-1:0]        in_data_b, x_data_b;
    logic                 busy_b, done_b, err_b, layer_rst_b, layer_req_b, x_valid_b;
    logic [N_OUT*DW-1:0]  y_in_b, y_out_b;

    logic [DW-1:0] model_buf [N_IN];
    int error_count = 0;
    int check_count = 0;

    nn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW),
                         .CLR_CYC(CLR_CYC), .WDOG(WDOG_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_we(in_we), .in_addr(in_addr),
        .in_data(in_data), .busy(busy), .done(done), .err(err),
        .layer_rst(layer_rst), .layer_req(layer_req), .step_ack(step_ack),
        .layer_ack(layer_ack), .x_trig(x_trig), .x_addr(x_addr), .x_data(x_data),
        .x_valid(x_valid), .y_in(y_in), .y_out(y_out)
    );

    nn_layer_sequencer #(.N_IN(N_IN_B), .N_OUT(N_OUT), .DW(DW), .AW(AW_B),
                         .CLR_CYC(CLR_CYC), .WDOG(WDOG_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_we(in_we_b), .in_addr(in_addr_b),
        .in_data(in_data_b), .busy(busy_b), .done(done_b), .err(err_b),
        .layer_rst(layer_rst_b), .layer_req(layer_req_b), .step_ack(step_ack_b),
        .layer_ack(layer_ack_b), .x_trig(x_trig_b), .x_addr(x_addr_b), .x_data(x_data_b),
        .x_valid(x_valid_b), .y_in(y_in_b), .y_out(y_out_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeBuf(input int addr, input logic [DW-1:0] data);
        in_we   = 1'b1;
        in_addr = AW'(addr);
        in_data = data;
        @(negedge clk);
        in_we   = 1'b0;
    endtask

    task automatic readCheck(input int addr, input string tag);
        x_trig = 1'b1;
        x_addr = AW'(addr);
        @(negedge clk);
        x_trig = 1'b0;
        checkOutput({tag, "_valid"}, 32'(x_valid), 32'(1));
        checkOutput({tag, "_data"}, 32'(x_data), 32'(model_buf[addr]));
    endtask

    // One complete inference on instance A, with the layer behaviour modelled here
    task automatic applyStimulus(input bit same_cycle_write, input bit busy_write,
                                 input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                 input logic [N_OUT*DW-1:0] y_val);
        writeBuf(0, w0);
        model_buf[0] = w0;
        if (!same_cycle_write) begin
            writeBuf(1, w1);
            model_buf[1] = w1;
        end
        start = 1'b1;
        if (same_cycle_write) begin
            in_we = 1'b1; in_addr = 1'b1; in_data = w1;
            model_buf[1] = w1;
        end
        @(negedge clk);
        start = 1'b0;
        in_we = 1'b0;
        checkOutput("busy_start", 32'(busy), 32'(1));
        checkOutput("err_clear", 32'(err), 32'(0));
        checkOutput("layer_rst_e0", 32'(layer_rst), 32'(0));
        for (int e = 1; e <= CLR_CYC + 1; e++) begin
            @(negedge clk);
            checkOutput("layer_rst", 32'(layer_rst), 32'(e <= CLR_CYC));
            checkOutput("layer_req_rise", 32'(layer_req), 32'(e == CLR_CYC + 1));
        end
        for (int i = 0; i < N_IN; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x_trig = 1'b1;
            x_addr = AW'(i);
            if (busy_write && i == 0) begin
                in_we = 1'b1; in_addr = '0; in_data = 8'd99;
            end
            @(negedge clk);
            x_trig = 1'b0;
            in_we  = 1'b0;
            checkOutput("run_x_valid", 32'(x_valid), 32'(1));
            checkOutput("run_x_data", 32'(x_data), 32'(model_buf[i]));
            step_ack  = 1'b1;
            layer_ack = (i == 0);
            @(negedge clk);
            step_ack  = 1'b0;
            layer_ack = 1'b0;
            checkOutput("req_after_ack", 32'(layer_req), 32'(i < N_IN - 1));
            checkOutput("done_in_run", 32'(done), 32'(0));
        end
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            checkOutput("wait_busy", 32'(busy), 32'(1));
            checkOutput("wait_done", 32'(done), 32'(0));
        end
        layer_ack = 1'b1;
        y_in      = y_val;
        @(negedge clk);
        layer_ack = 1'b0;
        y_in      = 16'($urandom());
        start     = 1'b1;
        checkOutput("y_capture", 32'(y_out), 32'(y_val));
        checkOutput("done_early", 32'(done), 32'(0));
        checkOutput("busy_in_done", 32'(busy), 32'(1));
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_pulse", 32'(done), 32'(1));
        checkOutput("y_out", 32'(y_out), 32'(y_val));
        checkOutput("busy_fall", 32'(busy), 32'(0));
        @(negedge clk);
        checkOutput("done_once", 32'(done), 32'(0));
        checkOutput("start_in_done_ignored", 32'(busy), 32'(0));
        checkOutput("y_hold", 32'(y_out), 32'(y_val));
        readCheck(0, "post_a0");
        readCheck(1, "post_a1");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int expire;
        int done_seen;
        start = 0; in_we = 0; step_ack = 0; layer_ack = 0; x_trig = 0;
        in_addr = '0; x_addr = '0; in_data = '0; y_in = '0;
        start_b = 0; in_we_b = 0; step_ack_b = 0; layer_ack_b = 0; x_trig_b = 0;
        in_addr_b = '0; x_addr_b = '0; in_data_b = '0; y_in_b = '0;
        for (int i = 0; i < N_IN; i++) model_buf[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_err", 32'(err), 32'(0));
        checkOutput("rst_layer_rst", 32'(layer_rst), 32'(1));
        checkOutput("rst_layer_req", 32'(layer_req), 32'(0));
        checkOutput("rst_x_valid", 32'(x_valid), 32'(0));
        checkOutput("rst_x_data", 32'(x_data), 32'(0));
        checkOutput("rst_y_out", 32'(y_out), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rel_layer_rst", 32'(layer_rst), 32'(0));
        checkOutput("rel_busy", 32'(busy), 32'(0));

        // Directed runs: nominal vector with a dropped busy write, then same-cycle write
        applyStimulus(1'b0, 1'b1, 8'd16, 8'hE0, {8'hFD, 8'h05});
        applyStimulus(1'b1, 1'b0, 8'd16, 8'd7, {8'h11, 8'h80});

        for (int a = 0; a < 3; a++) begin
            x_trig = 1'b1;
            x_addr = AW'(a % 2);
            @(negedge clk);
            checkOutput("b2b_valid", 32'(x_valid), 32'(1));
            checkOutput("b2b_data", 32'(x_data), 32'(model_buf[a % 2]));
        end
        x_trig = 1'b0;
        @(negedge clk);
        checkOutput("b2b_valid_drop", 32'(x_valid), 32'(0));

        in_we_b = 1'b1; in_addr_b = 2'd2; in_data_b = 8'h55;
        @(negedge clk);
        in_we_b = 1'b0;
        x_trig_b = 1'b1; x_addr_b = 2'd2;
        @(negedge clk);
        checkOutput("b_read2", 32'(x_data_b), 32'(8'h55));
        x_addr_b = 2'd3;
        @(negedge clk);
        x_trig_b = 1'b0;
        checkOutput("oor_valid", 32'(x_valid_b), 32'(1));
        checkOutput("oor_data", 32'(x_data_b), 32'(0));

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        expire    = CLR_CYC + 1 + WDOG_B;
        done_seen = 0;
        for (int e = 1; e <= expire + CLR_CYC + 1; e++) begin
            @(negedge clk);
            if (done_b) done_seen++;
            checkOutput("wd_err", 32'(err_b), 32'(e >= expire));
            checkOutput("wd_layer_rst", 32'(layer_rst_b),
                        32'((e <= CLR_CYC) || (e > expire && e <= expire + CLR_CYC)));
            checkOutput("wd_layer_req", 32'(layer_req_b), 32'(e > CLR_CYC && e < expire));
            checkOutput("wd_busy", 32'(busy_b), 32'(e < expire + CLR_CYC + 1));
        end
        repeat (3) begin
            @(negedge clk);
            if (done_b) done_seen++;
        end
        checkOutput("wd_err_sticky", 32'(err_b), 32'(1));
        checkOutput("wd_no_done", 32'(done_seen), 32'(0));
        checkOutput("wd_y_untouched", 32'(y_out_b), 32'(0));
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        checkOutput("wd_err_cleared", 32'(err_b), 32'(0));
        checkOutput("wd_restart_busy", 32'(busy_b), 32'(1));

        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'($urandom()), 1'($urandom()), DW'($urandom()), DW'($urandom()),
                          16'($urandom()));
        end

        writeBuf(0, 8'h3C);
        model_buf[0] = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CLR_CYC + 2) @(negedge clk);
        checkOutput("mid_run_req", 32'(layer_req), 32'(1));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_busy", 32'(busy), 32'(0));
        checkOutput("mid_rst_req", 32'(layer_req), 32'(0));
        checkOutput("mid_rst_y", 32'(y_out), 32'(0));
        checkOutput("mid_rst_layer_rst", 32'(layer_rst), 32'(1));
        rst = 1'b1;
        for (int i = 0; i < N_IN; i++) model_buf[i] = '0;
        @(negedge clk);
        checkOutput("mid_rel_layer_rst", 32'(layer_rst), 32'(0));
        checkOutput("mid_rel_busy", 32'(busy), 32'(0));
        readCheck(0, "buf_cleared");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end
endmodule
